// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED controller (off/on/blink/PWM) with register port
// A shared prescaler tick drives the PWM counter and every channel's blink counter.
module led_pwm_ctrl #(
    parameter int CHANNELS = 4,
    parameter int PWM_W    = 8,
    parameter int PRESC_W  = 16,
    parameter int ADDR_W   = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [31:0]         wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    output logic [CHANNELS-1:0] led
);

    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  pcnt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                tick;
    logic                presc_wr;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] inv_bits;
    logic [31:0]         cfg_word [CHANNELS];
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign unused_bits = &{1'b0, wr_data[7:3]};
    assign tick        = (pcnt == presc);
    assign presc_wr    = wr_en && (wr_addr == '0);

    // A PRESC write restarts the time base even if a tick lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            pcnt    <= '0;
            pwm_cnt <= '0;
        end else if (presc_wr) begin
            presc   <= wr_data[PRESC_W-1:0];
            pcnt    <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            pcnt    <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pcnt    <= pcnt + 1'b1;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [1:0]       mode;
        logic             inv;
        logic [PWM_W-1:0] duty;
        logic [15:0]      half;
        logic [15:0]      bcnt;
        logic             bst;
        logic             cfg_wr;
        logic [15:0]      thr;
        logic [31:0]      word;

        assign cfg_wr = wr_en && (wr_addr == ADDR_W'(n + 1));
        // HALF=0 behaves like HALF=1: toggle on every tick.
        assign thr    = (half == 16'd0) ? 16'd0 : half - 16'd1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode <= '0;
                inv  <= 1'b0;
                duty <= '0;
                half <= '0;
                bcnt <= '0;
                bst  <= 1'b0;
            end else if (cfg_wr) begin
                mode <= wr_data[1:0];
                inv  <= wr_data[2];
                duty <= wr_data[8 +: PWM_W];
                half <= wr_data[31:16];
                bcnt <= '0;
                bst  <= 1'b0;
            end else if (tick) begin
                if (bcnt >= thr) begin
                    bcnt <= '0;
                    bst  <= ~bst;
                end else begin
                    bcnt <= bcnt + 16'd1;
                end
            end
        end

        always_comb begin
            word              = '0;
            word[1:0]         = mode;
            word[2]           = inv;
            word[8 +: PWM_W]  = duty;
            word[31:16]       = half;
        end

        always_comb begin
            raw[n] = 1'b0;
            case (mode)
                2'd0: raw[n] = 1'b0;
                2'd1: raw[n] = 1'b1;
                2'd2: raw[n] = bst;
                2'd3: raw[n] = (pwm_cnt < duty);
                default: raw[n] = 1'b0;
            endcase
        end

        assign inv_bits[n] = inv;
        assign cfg_word[n] = word;
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr == '0) begin
            rd_mux = 32'(presc);
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (rd_addr == ADDR_W'(n + 1)) begin
                rd_mux = cfg_word[n];
            end
        end
    end

    // Register contents are sampled before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= raw ^ inv_bits;
        end
    end

endmodule
